// File: rtl/wheel_cmd_scheduler.sv
// Four-wheel speed command scheduler: one shared magnitude/shift/clamp/slew datapath visits each
// wheel in turn, then all duties and directions commit together. Includes a command watchdog.
module wheel_cmd_scheduler #(
    parameter int unsigned LIMIT     = 2500,
    parameter int unsigned SHIFT     = 12,
    parameter int unsigned SLEW_STEP = 200,
    parameter int unsigned TIMEOUT   = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [31:0] cmd0,
    input  logic [31:0] cmd1,
    input  logic [31:0] cmd2,
    input  logic [31:0] cmd3,
    output logic        cmd_ready,
    output logic [15:0] duty0,
    output logic [15:0] duty1,
    output logic [15:0] duty2,
    output logic [15:0] duty3,
    output logic [3:0]  dir,
    output logic        update_done,
    output logic        timeout,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    localparam logic [31:0] LIMIT_V = 32'(LIMIT);
    localparam logic [15:0] SLEW_V  = 16'(SLEW_STEP);
    localparam logic [31:0] TRIP_AT = 32'(TIMEOUT - 1);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_frame [4];
    logic [15:0] r_stage_duty [4];
    logic [3:0]  r_stage_dir;
    logic [15:0] r_duty [4];
    logic [3:0]  r_dir;
    logic [31:0] r_wdog;
    logic        r_ready;
    logic        r_done;
    logic        r_timeout;
    logic        r_overrun;

    logic        w_accept;
    logic        w_trip;
    logic [31:0] w_cmd;
    logic [31:0] w_mag;
    logic [31:0] w_shifted;
    logic [15:0] w_tgt;
    logic [15:0] w_cur;
    logic [15:0] w_new;
    logic        w_ndir;
    logic        w_cdir;
    logic        w_reverse;
    logic        w_new_dir;

    assign w_accept = cmd_valid && r_ready;
    assign w_trip   = !w_accept && (r_wdog == TRIP_AT);

    // With slew disabled a reversal also jumps straight to the new target instead of stalling.
    always_comb begin
        w_cmd = r_frame[r_idx];
        if (!w_cmd[31])
            w_mag = w_cmd;
        else if (w_cmd == 32'h8000_0000)
            w_mag = 32'h7FFF_FFFF;
        else
            w_mag = ~w_cmd + 32'd1;
        w_shifted = w_mag >> SHIFT;
        w_tgt     = (w_shifted > LIMIT_V) ? LIMIT_V[15:0] : w_shifted[15:0];
        w_ndir    = (w_tgt != 16'd0) && w_cmd[31];
        w_cur     = r_duty[r_idx];
        w_cdir    = r_dir[r_idx];
        w_reverse = (w_cur != 16'd0) && (w_tgt != 16'd0) && (w_ndir != w_cdir);

        if (SLEW_V == 16'd0)
            w_new = w_tgt;
        else if (w_reverse)
            w_new = (w_cur > SLEW_V) ? (w_cur - SLEW_V) : 16'd0;
        else if (w_tgt > w_cur)
            w_new = ((w_tgt - w_cur) > SLEW_V) ? (w_cur + SLEW_V) : w_tgt;
        else
            w_new = ((w_cur - w_tgt) > SLEW_V) ? (w_cur - SLEW_V) : w_tgt;

        if (w_new == 16'd0)
            w_new_dir = 1'b0;
        else if (w_reverse && (SLEW_V != 16'd0))
            w_new_dir = w_cdir;
        else
            w_new_dir = w_ndir;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
            r_wdog      <= '0;
            r_dir       <= '0;
            r_stage_dir <= '0;
            for (int i = 0; i < 4; i++) begin
                r_frame[i]      <= '0;
                r_stage_duty[i] <= '0;
                r_duty[i]       <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_overrun <= cmd_valid && !r_ready;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_frame[0] <= cmd0;
                        r_frame[1] <= cmd1;
                        r_frame[2] <= cmd2;
                        r_frame[3] <= cmd3;
                        r_idx      <= 2'd0;
                        r_ready    <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_stage_duty[r_idx] <= w_new;
                    r_stage_dir[r_idx]  <= w_new_dir;
                    r_idx               <= r_idx + 2'd1;
                    if (r_idx == 2'd3)
                        r_state <= COMMIT;
                end
                COMMIT: begin
                    for (int i = 0; i < 4; i++)
                        r_duty[i] <= r_stage_duty[i];
                    r_dir   <= r_stage_dir;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Watchdog: an accept always wins over a trip on the same edge.
            if (w_accept) begin
                r_wdog    <= '0;
                r_timeout <= 1'b0;
            end else begin
                if (r_wdog != '1)
                    r_wdog <= r_wdog + 32'd1;
                if (w_trip) begin
                    r_timeout <= 1'b1;
                    r_dir     <= '0;
                    for (int i = 0; i < 4; i++)
                        r_duty[i] <= '0;
                end
            end
        end
    end

    assign cmd_ready   = r_ready;
    assign duty0       = r_duty[0];
    assign duty1       = r_duty[1];
    assign duty2       = r_duty[2];
    assign duty3       = r_duty[3];
    assign dir         = r_dir;
    assign update_done = r_done;
    assign timeout     = r_timeout;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_wheel_cmd_scheduler.sv
// Directed bench for wheel_cmd_scheduler: DUT "a" uses the default slew step, DUT "b" has slew
// disabled; both share stimulus and a shortened watchdog period of 1000 cycles.
module tb_wheel_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmdValid = 1'b0;
    logic [31:0] cmd [4];

    logic        aReady, bReady;
    logic [15:0] aDuty [4];
    logic [15:0] bDuty [4];
    logic [3:0]  aDir, bDir;
    logic        aDone, bDone, aTimeout, bTimeout, aOverrun, bOverrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wheel_cmd_scheduler #(.SLEW_STEP(200), .TIMEOUT(1000)) dutA (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmdValid),
        .cmd0(cmd[0]), .cmd1(cmd[1]), .cmd2(cmd[2]), .cmd3(cmd[3]),
        .cmd_ready(aReady),
        .duty0(aDuty[0]), .duty1(aDuty[1]), .duty2(aDuty[2]), .duty3(aDuty[3]),
        .dir(aDir), .update_done(aDone), .timeout(aTimeout), .overrun(aOverrun)
    );

    wheel_cmd_scheduler #(.SLEW_STEP(0), .TIMEOUT(1000)) dutB (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmdValid),
        .cmd0(cmd[0]), .cmd1(cmd[1]), .cmd2(cmd[2]), .cmd3(cmd[3]),
        .cmd_ready(bReady),
        .duty0(bDuty[0]), .duty1(bDuty[1]), .duty2(bDuty[2]), .duty3(bDuty[3]),
        .dir(bDir), .update_done(bDone), .timeout(bTimeout), .overrun(bOverrun)
    );

    // Presents one frame and returns 1 time unit after its accept edge.
    task automatic applyStimulus(input logic [31:0] c0, input logic [31:0] c1,
                                 input logic [31:0] c2, input logic [31:0] c3);
        @(negedge clk);
        cmd[0] = c0; cmd[1] = c1; cmd[2] = c2; cmd[3] = c3;
        cmdValid = 1'b1;
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
    endtask

    task automatic runFrame(input logic [31:0] c0, input logic [31:0] c1,
                            input logic [31:0] c2, input logic [31:0] c3);
        applyStimulus(c0, c1, c2, c3);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic applyReset;
        cmdValid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cmdValid = 1'b0;
        for (int i = 0; i < 4; i++) cmd[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (aReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", aReady); end
        checks++; if (aDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", aDone); end
        checks++; if (aTimeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b expected 0", aTimeout); end
        checks++; if (aOverrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got %b expected 0", aOverrun); end
        checks++; if (aDir !== 4'b0000) begin errors++; $display("[TB] FAIL reset_dir got %b expected 0000", aDir); end
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (aDuty[w] !== 16'd0) begin errors++; $display("[TB] FAIL reset_duty%0d got %0d expected 0", w, aDuty[w]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_no_slew;
        logic [15:0] expB [4];
        logic [15:0] expA [4];
        expB = '{16'd1600, 16'd1600, 16'd2500, 16'd0};
        expA = '{16'd200, 16'd200, 16'd200, 16'd0};
        applyStimulus(32'h0064_0000, 32'hFF9C_0000, 32'h7FFF_FFFF, 32'h0000_0FFF);
        checks++; if (aReady !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready got %b expected 0", aReady); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bDone !== 1'b0) begin errors++; $display("[TB] FAIL early_done got %b expected 0", bDone); end
        checks++; if (bDuty[0] !== 16'd0) begin errors++; $display("[TB] FAIL early_duty got %0d expected 0", bDuty[0]); end
        checks++; if (bReady !== 1'b0) begin errors++; $display("[TB] FAIL e4_ready got %b expected 0", bReady); end
        @(posedge clk);
        #1;
        checks++; if (bDone !== 1'b1) begin errors++; $display("[TB] FAIL commit_done got %b expected 1", bDone); end
        checks++; if (bReady !== 1'b1) begin errors++; $display("[TB] FAIL commit_ready got %b expected 1", bReady); end
        checks++; if (bDir !== 4'b0010) begin errors++; $display("[TB] FAIL noslew_dir got %b expected 0010", bDir); end
        checks++; if (aDir !== 4'b0010) begin errors++; $display("[TB] FAIL slew_dir got %b expected 0010", aDir); end
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (bDuty[w] !== expB[w]) begin errors++; $display("[TB] FAIL noslew_duty%0d got %0d expected %0d", w, bDuty[w], expB[w]); end
            checks++;
            if (aDuty[w] !== expA[w]) begin errors++; $display("[TB] FAIL slew_first_duty%0d got %0d expected %0d", w, aDuty[w], expA[w]); end
        end
        @(posedge clk);
        #1;
        checks++; if (bDone !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_end got %b expected 0", bDone); end
    endtask

    task automatic test_slew;
        int expDuty;
        applyReset;
        for (int f = 1; f <= 10; f++) begin
            runFrame(32'h0064_0000, 32'd0, 32'd0, 32'd0);
            expDuty = (f * 200 > 1600) ? 1600 : f * 200;
            checks++;
            if (aDuty[0] !== 16'(expDuty)) begin errors++; $display("[TB] FAIL ramp_duty frame %0d got %0d expected %0d", f, aDuty[0], expDuty); end
            checks++;
            if (bDuty[0] !== 16'd1600) begin errors++; $display("[TB] FAIL ramp_noslew frame %0d got %0d expected 1600", f, bDuty[0]); end
            checks++;
            if (aDir[0] !== 1'b0) begin errors++; $display("[TB] FAIL ramp_dir frame %0d got %b expected 0", f, aDir[0]); end
            checks++;
            if (aDone !== 1'b1) begin errors++; $display("[TB] FAIL ramp_done frame %0d got %b expected 1", f, aDone); end
        end
    endtask

    task automatic test_reversal;
        int expDuty;
        logic expDir;
        for (int f = 1; f <= 9; f++) begin
            runFrame(32'hFF9C_0000, 32'd0, 32'd0, 32'd0);
            expDuty = (f <= 8) ? 1600 - 200 * f : 200;
            expDir  = (f == 9);
            checks++;
            if (aDuty[0] !== 16'(expDuty)) begin errors++; $display("[TB] FAIL rev_duty frame %0d got %0d expected %0d", f, aDuty[0], expDuty); end
            checks++;
            if (aDir[0] !== expDir) begin errors++; $display("[TB] FAIL rev_dir frame %0d got %b expected %b", f, aDir[0], expDir); end
        end
    endtask

    task automatic test_boundary;
        logic [15:0] expB [4];
        logic [15:0] expA [4];
        expB = '{16'd2500, 16'd1, 16'd1, 16'd0};
        expA = '{16'd200, 16'd1, 16'd1, 16'd0};
        applyReset;
        runFrame(32'h8000_0000, 32'hFFFF_F000, 32'h0000_1000, 32'hFFFF_FFFF);
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (bDuty[w] !== expB[w]) begin errors++; $display("[TB] FAIL edge_noslew_duty%0d got %0d expected %0d", w, bDuty[w], expB[w]); end
            checks++;
            if (aDuty[w] !== expA[w]) begin errors++; $display("[TB] FAIL edge_slew_duty%0d got %0d expected %0d", w, aDuty[w], expA[w]); end
        end
        checks++; if (bDir !== 4'b0011) begin errors++; $display("[TB] FAIL edge_noslew_dir got %b expected 0011", bDir); end
        checks++; if (aDir !== 4'b0011) begin errors++; $display("[TB] FAIL edge_slew_dir got %b expected 0011", aDir); end
    endtask

    task automatic test_watchdog;
        applyReset;
        applyStimulus(32'h0064_0000, 32'd0, 32'd0, 32'd0);
        repeat (999) @(posedge clk);
        #1;
        checks++; if (aTimeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_early got %b expected 0", aTimeout); end
        checks++; if (aDuty[0] !== 16'd200) begin errors++; $display("[TB] FAIL wd_hold1 got %0d expected 200", aDuty[0]); end
        applyStimulus(32'h0064_0000, 32'd0, 32'd0, 32'd0);
        checks++; if (aTimeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_accept_wins got %b expected 0", aTimeout); end
        checks++; if (aDuty[0] !== 16'd200) begin errors++; $display("[TB] FAIL wd_no_force got %0d expected 200", aDuty[0]); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (aDuty[0] !== 16'd400) begin errors++; $display("[TB] FAIL wd_second_commit got %0d expected 400", aDuty[0]); end
        repeat (994) @(posedge clk);
        #1;
        checks++; if (aTimeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_early2 got %b expected 0", aTimeout); end
        checks++; if (bDuty[0] !== 16'd1600) begin errors++; $display("[TB] FAIL wd_hold2 got %0d expected 1600", bDuty[0]); end
        @(posedge clk);
        #1;
        checks++; if (aTimeout !== 1'b1) begin errors++; $display("[TB] FAIL wd_trip got %b expected 1", aTimeout); end
        checks++; if (bTimeout !== 1'b1) begin errors++; $display("[TB] FAIL wd_trip_b got %b expected 1", bTimeout); end
        checks++; if (aDuty[0] !== 16'd0) begin errors++; $display("[TB] FAIL wd_force_a got %0d expected 0", aDuty[0]); end
        checks++; if (bDuty[0] !== 16'd0) begin errors++; $display("[TB] FAIL wd_force_b got %0d expected 0", bDuty[0]); end
        checks++; if (aDir !== 4'b0000) begin errors++; $display("[TB] FAIL wd_dir got %b expected 0000", aDir); end
        applyStimulus(32'h0064_0000, 32'd0, 32'd0, 32'd0);
        checks++; if (aTimeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_clear got %b expected 0", aTimeout); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (aDuty[0] !== 16'd200) begin errors++; $display("[TB] FAIL wd_ramp got %0d expected 200", aDuty[0]); end
        checks++; if (bDuty[0] !== 16'd1600) begin errors++; $display("[TB] FAIL wd_ramp_b got %0d expected 1600", bDuty[0]); end
    endtask

    task automatic test_back_to_back;
        logic expReady;
        logic expOverrun;
        int   expDuty;
        applyReset;
        @(negedge clk);
        cmd[0] = 32'h0064_0000; cmd[1] = '0; cmd[2] = '0; cmd[3] = '0;
        cmdValid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk);
            #1;
            expReady   = (k % 6 == 5);
            expOverrun = (k % 6 != 0);
            expDuty    = 200 * ((k + 1) / 6);
            checks++;
            if (aReady !== expReady) begin errors++; $display("[TB] FAIL b2b_ready edge %0d got %b expected %b", k, aReady, expReady); end
            checks++;
            if (aOverrun !== expOverrun) begin errors++; $display("[TB] FAIL b2b_overrun edge %0d got %b expected %b", k, aOverrun, expOverrun); end
            checks++;
            if (aDone !== expReady) begin errors++; $display("[TB] FAIL b2b_done edge %0d got %b expected %b", k, aDone, expReady); end
            checks++;
            if (aDuty[0] !== 16'(expDuty)) begin errors++; $display("[TB] FAIL b2b_duty edge %0d got %0d expected %0d", k, aDuty[0], expDuty); end
        end
        @(negedge clk);
        cmdValid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_midframe;
        applyReset;
        runFrame(32'h0064_0000, 32'hFF9C_0000, 32'd0, 32'd0);
        applyStimulus(32'h0064_0000, 32'hFF9C_0000, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (aReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %b expected 1", aReady); end
        checks++; if (bDuty[0] !== 16'd0) begin errors++; $display("[TB] FAIL mid_duty0 got %0d expected 0", bDuty[0]); end
        checks++; if (bDuty[1] !== 16'd0) begin errors++; $display("[TB] FAIL mid_duty1 got %0d expected 0", bDuty[1]); end
        checks++; if (bDir !== 4'b0000) begin errors++; $display("[TB] FAIL mid_dir got %b expected 0000", bDir); end
        checks++; if (aDuty[0] !== 16'd0) begin errors++; $display("[TB] FAIL mid_duty_a got %0d expected 0", aDuty[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bDone !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_commit cycle %0d got %b expected 0", k, bDone); end
            checks++;
            if (bDuty[0] !== 16'd0) begin errors++; $display("[TB] FAIL mid_no_partial cycle %0d got %0d expected 0", k, bDuty[0]); end
        end
    endtask

    initial begin
        test_reset;
        test_no_slew;
        test_slew;
        test_reversal;
        test_boundary;
        test_watchdog;
        test_back_to_back;
        test_reset_midframe;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/wheel_cmd_scheduler.md
# wheel_cmd_scheduler

Time-multiplexed scheduler for the four wheel-drive channels. It latches a frame of four signed 32-bit speed commands and runs them one wheel per cycle through a single shared conversion datapath: magnitude/direction split, right shift, clamp to limit, then slew limiting. All four PWM duty/direction outputs are committed simultaneously. It sits between the command decoder and the four PWM generators, and includes a command watchdog that forces all wheels to zero duty when commands stop arriving.

## Interface
Parameters:
- LIMIT, 2500 — maximum duty value after scaling.
- SHIFT, 12 — right-shift applied to the command magnitude.
- SLEW_STEP, 200 — maximum per-frame change of a committed duty; 0 disables slew limiting.
- TIMEOUT, 5000000 — watchdog period in clk cycles; legal values are 16 to 2^32-1.

Ports:
- Reset is rst_n, asynchronous, active-low; the clock is clk.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  new command frame strobe
- cmd0..cmd3  in  32 each  signed two's-complement wheel speed commands
- cmd_ready  out  1  scheduler idle; a frame is accepted only when cmd_valid and cmd_ready are both high at a clk edge
- duty0..duty3  out  16 each  committed unsigned duty, range 0..LIMIT
- dir  out  4  committed direction per wheel; bit i = 1 means reverse
- update_done  out  1  one-cycle pulse after each commit
- timeout  out  1  watchdog tripped; held until the next accepted frame
- overrun  out  1  one-cycle pulse when cmd_valid arrives while cmd_ready = 0

## Operation
- FSM states: IDLE, CALC, COMMIT.
  - IDLE: cmd_ready = 1. An accept captures cmd0..3 into frame registers, sets idx = 0, and moves to CALC.
  - CALC: processes wheel idx in one cycle and writes the result to staging registers. idx counts 0 to 3; after idx = 3 the FSM moves to COMMIT.
  - COMMIT: copies all staging registers to duty0..3 and dir in a single edge, pulses update_done, and returns to IDLE.
- Per-wheel datapath, all unsigned 32-bit:
  - If cmd[31] = 0: mag = cmd. Otherwise mag = ~cmd + 1. The value 0x80000000 saturates to 0x7FFFFFFF.
  - tgt = min(mag >> SHIFT, LIMIT). ndir = cmd[31] when tgt != 0, else 0.
- Slew rule, with cur and cdir taken from the committed outputs:
  - Reversal (cur != 0 and tgt != 0 and ndir != cdir): new = cur - min(cur, SLEW_STEP) and dir stays cdir. The reversal completes in later frames.
  - Otherwise new moves from cur toward tgt by at most SLEW_STEP; it goes straight to tgt when SLEW_STEP = 0.
  - The direction output is 0 whenever new = 0. When not reversing and new != 0, it is ndir.
- Watchdog:
  - The counter clears to 0 on every accept edge, increments every cycle otherwise, and saturates.
  - When it reaches TIMEOUT with no accept on that edge: timeout becomes 1, duty0..3 are forced to 0 and dir to 0 on that edge, bypassing slew.
  - An accept on the same edge wins: no trip occurs and the counter clears.
  - An accepted frame clears timeout on its accept edge. Ramp-up after a trip then starts from 0.
- cmd_valid is ignored while in CALC or COMMIT. Such a frame is dropped and overrun pulses on the next cycle. This does not affect the watchdog.
- Reset values: state IDLE, cmd_ready 1, all duties 0, dir 0, update_done 0, timeout 0, overrun 0, counter 0, staging registers 0.
- Asserting reset mid-frame aborts the frame; no partial commit occurs.

## Timing
- Accept at edge E0. Wheels 0..3 are computed at E1..E4. Outputs change at E5.
- update_done is high from E5 to E6.
- cmd_ready is low from E0 to E5 and high after E5.
- Earliest next accept is E6, giving a throughput of one frame per 6 cycles.
- Watchdog trip occurs exactly TIMEOUT cycles after the last accept edge.
- Duties change only at commit edges, at a trip edge, or at reset.

## Test plan
- Slew disabled, SLEW_STEP = 0. Frame: cmd0 = 0x00640000, cmd1 = 0xFF9C0000, cmd2 = 0x7FFFFFFF, cmd3 = 0x00000FFF.
  - Expected at E5: duty = 1600 / 1600 / 2500 / 0, dir = 4'b0010, and an update_done pulse.
- Slew enabled at the default. Repeated frames of cmd0 = 0x00640000, starting from 0.
  - Expected duty0 per frame: 200, 400, …, 1600 (reaches 1600 at frame 8), then holds at 1600.
- Reversal. From duty0 = 1600, dir0 = 0, apply repeated frames of cmd0 = 0xFF9C0000.
  - Expected duty0: 1400 … 0 over 8 frames with dir0 = 0. Frame 9 gives 200 with dir0 = 1.
- Watchdog with TIMEOUT = 1000.
  - Accept, then idle: at E0 + 1000, duties = 0, dir = 0, timeout = 1.
  - The next frame clears timeout at its accept edge and ramps from 0.
- Overrun. Hold cmd_valid high continuously.
  - Expected: accepts at E0, E6, E12, …, with an overrun pulse during each busy window; outputs stay correct.
- Reset mid-frame. Assert rst_n low at E2.
  - Expected: all outputs return to reset values immediately, and no update_done pulse occurs.
